// File: rtl/alu_issue_seq.sv
// ALU-control issue stage: decodes class flags/funct3/funct7 into a 4-bit ALU op and
// issues one beat per scalar instruction or one beat per enabled lane for VR instructions.
module alu_issue_seq #(
  parameter int LANES  = 4,
  parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              R,
  input  logic              I,
  input  logic              U,
  input  logic              VR,
  input  logic              abs,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [LANES-1:0]  vmask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_op,
  output logic [LANE_W-1:0] lane_idx,
  output logic              last,
  output logic              illegal
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [3:0]          alu_op_q, alu_op_d;
  logic [LANE_W-1:0]   lane_idx_q, lane_idx_d;
  logic                last_q, last_d;
  logic                illegal_q, illegal_d;
  logic [LANES-1:0]    mask_q, mask_d;

  logic                fire, accept;
  logic [4:0]          dec;
  logic [LANES-1:0]    rem_in, rem_q;

  // Returns {illegal, op}; op is forced to 0 for illegal encodings.
  function automatic logic [4:0] decode(input logic r, input logic i, input logic u,
                                        input logic vr, input logic ab,
                                        input logic [2:0] f3, input logic [6:0] f7);
    logic [2:0] n;
    logic [3:0] op;
    logic [3:0] base;
    logic       ill;
    n   = {2'b00, r} + {2'b00, i} + {2'b00, u} + {2'b00, vr};
    ill = 1'b0;
    op  = 4'd0;
    case (f3)
      3'd0:    base = 4'd0;
      3'd1:    base = 4'd5;
      3'd2:    base = 4'd8;
      3'd3:    base = 4'd9;
      3'd4:    base = 4'd2;
      3'd5:    base = 4'd6;
      3'd6:    base = 4'd3;
      default: base = 4'd4;
    endcase
    if (n == 3'd0) begin
      if (ab) op = 4'd12;
      else    ill = 1'b1;
    end else if (n != 3'd1) begin
      ill = 1'b1;
    end else if (u) begin
      op = 4'd11;
    end else if (i) begin
      if (f3 == 3'd1) begin
        if (f7 == 7'h00) op = base;
        else             ill = 1'b1;
      end else if (f3 == 3'd5) begin
        if (f7 == 7'h00)      op = 4'd6;
        else if (f7 == 7'h20) op = 4'd7;
        else                  ill = 1'b1;
      end else begin
        op = base;
      end
    end else begin
      case (f7)
        7'h00: op = base;
        7'h20: begin
          if (f3 == 3'd0)      op = 4'd1;
          else if (f3 == 3'd5) op = 4'd7;
          else                 ill = 1'b1;
        end
        7'h01: begin
          if (f3 == 3'd0)      op = 4'd13;
          else if (f3 == 3'd4) op = 4'd14;
          else if (f3 == 3'd6) op = 4'd15;
          else                 ill = 1'b1;
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) op = 4'd0;
    return {ill, op};
  endfunction

  function automatic logic [LANE_W-1:0] low_lane(input logic [LANES-1:0] m);
    logic [LANE_W-1:0] res;
    res = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (m[k]) res = LANE_W'(k);
    end
    return res;
  endfunction

  function automatic logic [LANES-1:0] clr_low(input logic [LANES-1:0] m);
    logic [LANES-1:0] res;
    logic             found;
    res   = m;
    found = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (m[k] && !found) begin
        res[k] = 1'b0;
        found  = 1'b1;
      end
    end
    return res;
  endfunction

  assign fire     = out_valid_q && out_ready;
  assign in_ready = (state_q == IDLE) || (fire && last_q);
  assign accept   = in_valid && in_ready;
  assign dec      = decode(R, I, U, VR, abs, funct3, funct7);
  assign rem_in   = clr_low(vmask);
  assign rem_q    = clr_low(mask_q);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    lane_idx_d  = lane_idx_q;
    last_d      = last_q;
    illegal_d   = illegal_q;
    mask_d      = mask_q;
    if (accept) begin
      if (dec[4]) begin
        state_d     = ISSUE;
        out_valid_d = 1'b1;
        alu_op_d    = 4'd0;
        lane_idx_d  = '0;
        last_d      = 1'b1;
        illegal_d   = 1'b1;
        mask_d      = '0;
      end else if (VR) begin
        // An empty mask consumes the instruction without producing any beat.
        if (vmask == '0) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          mask_d      = '0;
        end else begin
          state_d     = ISSUE;
          out_valid_d = 1'b1;
          alu_op_d    = dec[3:0];
          lane_idx_d  = low_lane(vmask);
          last_d      = (rem_in == '0);
          illegal_d   = 1'b0;
          mask_d      = rem_in;
        end
      end else begin
        state_d     = ISSUE;
        out_valid_d = 1'b1;
        alu_op_d    = dec[3:0];
        lane_idx_d  = '0;
        last_d      = 1'b1;
        illegal_d   = 1'b0;
        mask_d      = '0;
      end
    end else if (fire) begin
      if (last_q) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end else begin
        lane_idx_d = low_lane(mask_q);
        last_d     = (rem_q == '0);
        mask_d     = rem_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      alu_op_q    <= 4'd0;
      lane_idx_q  <= '0;
      last_q      <= 1'b0;
      illegal_q   <= 1'b0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      lane_idx_q  <= lane_idx_d;
      last_q      <= last_d;
      illegal_q   <= illegal_d;
      mask_q      <= mask_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = alu_op_q;
  assign lane_idx  = lane_idx_q;
  assign last      = last_q;
  assign illegal   = illegal_q;

endmodule
